// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises and edge-latches up to 8 IRQs into W1C status, masks
// with ENABLE and drives a gap-limited irq_out. Define IRQ_LEVEL_MODE_EN for per-source level mode.
module irq_ctrl #(
  parameter logic [4:0] BASE_ADDR  = 5'h18,
  parameter int         NUM_IRQS   = 8,
  parameter logic [7:0] DFL_ENABLE = 8'h00,
  parameter logic [7:0] MIN_GAP    = 8'd4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic                ce,
  input  logic                hold,
  input  logic [NUM_IRQS-1:0] irq_in,
  output logic                irq_out
);

  localparam logic [4:0] ADDR_STATUS = BASE_ADDR;
  localparam logic [4:0] ADDR_ENABLE = BASE_ADDR + 5'd1;
  localparam logic [4:0] ADDR_RAW    = BASE_ADDR + 5'd2;
`ifdef IRQ_LEVEL_MODE_EN
  localparam logic [4:0] ADDR_MODE   = BASE_ADDR + 5'd3;
`endif

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  logic       we_status;
  logic       we_enable;
  logic [7:0] raw_vec;
  logic [7:0] status_vec;
  logic [7:0] enable_vec;
  logic       pending;
`ifdef IRQ_LEVEL_MODE_EN
  logic       we_mode;
  logic [7:0] mode_vec;
`endif

  state_t     state_reg;
  logic [7:0] gap_cnt_reg;
  logic       irq_out_reg;

  assign we_status = csr_we && (csr_a == ADDR_STATUS);
  assign we_enable = csr_we && (csr_a == ADDR_ENABLE);
`ifdef IRQ_LEVEL_MODE_EN
  assign we_mode   = csr_we && (csr_a == ADDR_MODE);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_src
      if (gi < NUM_IRQS) begin : g_used
        logic sync_reg;
        logic raw_reg;
        logic prev_reg;
        logic status_reg;
        logic enable_reg;
`ifdef IRQ_LEVEL_MODE_EN
        logic mode_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            mode_reg <= 1'b0;
          end else if (we_mode) begin
            mode_reg <= csr_di[gi];
          end
        end

        assign mode_vec[gi] = mode_reg;
`endif

        // Sync chain resets high so a source already asserted at release raises no edge.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sync_reg   <= 1'b1;
            raw_reg    <= 1'b1;
            prev_reg   <= 1'b1;
            status_reg <= 1'b0;
            enable_reg <= DFL_ENABLE[gi];
          end else begin
            sync_reg <= irq_in[gi];
            raw_reg  <= sync_reg;
            prev_reg <= raw_reg;
            if (we_enable) begin
              enable_reg <= csr_di[gi];
            end
`ifdef IRQ_LEVEL_MODE_EN
            if (mode_reg) begin
              status_reg <= raw_reg;
            end else
`endif
            if (raw_reg && !prev_reg) begin
              status_reg <= 1'b1;
            end else if (we_status && csr_di[gi]) begin
              status_reg <= 1'b0;
            end
          end
        end

        assign raw_vec[gi]    = raw_reg;
        assign status_vec[gi] = status_reg;
        assign enable_vec[gi] = enable_reg;
      end else begin : g_unused
        assign raw_vec[gi]    = 1'b0;
        assign status_vec[gi] = 1'b0;
        assign enable_vec[gi] = 1'b0;
`ifdef IRQ_LEVEL_MODE_EN
        assign mode_vec[gi]   = 1'b0;
`endif
      end
    end
  endgenerate

  assign pending = |(status_vec & enable_vec);

  always_comb begin
    csr_do = 8'h00;
    case (csr_a)
      ADDR_STATUS: csr_do = status_vec;
      ADDR_ENABLE: csr_do = enable_vec;
      ADDR_RAW:    csr_do = raw_vec;
`ifdef IRQ_LEVEL_MODE_EN
      ADDR_MODE:   csr_do = mode_vec;
`endif
      default:     csr_do = 8'h00;
    endcase
  end

  // GAP always lasts at least one clk, even with MIN_GAP of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= 8'd0;
      irq_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pending && !hold) begin
            state_reg   <= ASSERT;
            irq_out_reg <= 1'b1;
          end
        end
        ASSERT: begin
          if (!pending || hold) begin
            state_reg   <= GAP;
            gap_cnt_reg <= MIN_GAP;
            irq_out_reg <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt_reg == 8'd0) begin
            state_reg <= IDLE;
          end else if (ce) begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          irq_out_reg <= 1'b0;
        end
      endcase
    end
  end

  assign irq_out = irq_out_reg;

endmodule
